// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule
// Purpose  : Iterative AES-128/192/256 key expansion. Generates one 32-bit
//            schedule word per clock into an on-chip word store and serves
//            any round key through a registered random-access read port.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            start, key_len  - expansion request (IDLE only), 0/1/2 = 128/192/256
//            cipher_key      - MSB-aligned cipher key
//            busy/done/ready - expansion running / completion pulse / schedule valid
//            err             - one-cycle pulse on an illegal start
//            rk_idx, rk_data - round-key read index, registered 128-bit round key
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] cipher_key,
    output logic                    busy,
    output logic                    done,
    output logic                    ready,
    output logic                    err,
    input  logic [3:0]              rk_idx,
    output logic [127:0]            rk_data
);

    localparam int C_NK_MAX    = MAX_KEY_BITS / 32;
    localparam int C_NR_MAX    = C_NK_MAX + 6;
    localparam int C_MAX_WORDS = 4 * (C_NR_MAX + 1);
    localparam int C_AW        = $clog2(C_MAX_WORDS);
    localparam int C_WIN_AW    = (C_NK_MAX > 1) ? $clog2(C_NK_MAX) : 1;

    localparam logic [7:0] C_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } state_t;

    // Nk for a key_len code; 0 marks the reserved code.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'd0:    nk_of = 4'd4;
            2'd1:    nk_of = 4'd6;
            2'd2:    nk_of = 4'd8;
            default: nk_of = 4'd0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          key_len_q, key_len_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [C_AW-1:0]     i_q, i_d;
    logic [2:0]          mod_q, mod_d;       // i mod Nk, tracked incrementally
    logic [31:0]         win_q   [0:C_NK_MAX-1];
    logic [31:0]         win_d   [0:C_NK_MAX-1];
    logic [31:0]         store_q [0:C_MAX_WORDS-1];
    logic [31:0]         store_d [0:C_MAX_WORDS-1];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [127:0]        rk_data_q, rk_data_d;

    logic [31:0]         key_word [0:C_NK_MAX-1];
    logic [3:0]          nk_in, nk_cur, nr_cur;
    logic                start_legal;
    logic [C_AW-1:0]     last_idx, rk_base;
    logic [31:0]         prev_word, old_word, sub_in, sub_out, temp_word, new_word;

    generate
        for (genvar g = 0; g < C_NK_MAX; g++) begin : g_key_word
            assign key_word[g] = cipher_key[MAX_KEY_BITS-1-32*g -: 32];
        end
    endgenerate

    assign nk_in       = nk_of(key_len);
    assign nk_cur      = nk_of(key_len_q);
    assign nr_cur      = nk_cur + 4'd6;
    assign start_legal = (key_len != 2'd3) && (int'(nk_in) <= C_NK_MAX);
    assign last_idx    = C_AW'({nk_cur + 4'd7, 2'b00} - 6'd1);
    assign rk_base     = C_AW'({rk_idx, 2'b00});

    // Window holds the last Nk words, newest at index 0, so w[i-1] is
    // always win_q[0] and w[i-Nk] is win_q[Nk-1].
    assign prev_word = win_q[0];
    assign old_word  = win_q[C_WIN_AW'(nk_cur - 4'd1)];

    // The four S-boxes are shared between the RotWord and plain SubWord cases.
    assign sub_in = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            assign sub_out[8*b +: 8] = C_SBOX[sub_in[8*b +: 8]];
        end
    endgenerate

    always_comb begin
        temp_word = prev_word;
        if (mod_q == 3'd0) begin
            temp_word = sub_out ^ {rcon_q, 24'h0};
        end else if ((nk_cur == 4'd8) && (mod_q == 3'd4)) begin
            temp_word = sub_out;
        end
        new_word = old_word ^ temp_word;
    end

    always_comb begin
        state_d   = state_q;
        key_len_d = key_len_q;
        rcon_d    = rcon_q;
        i_d       = i_q;
        mod_d     = mod_q;
        win_d     = win_q;
        store_d   = store_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        key_len_d = key_len;
                        rcon_d    = 8'h01;
                        i_d       = C_AW'(nk_in);
                        mod_d     = 3'd0;
                        ready_d   = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = S_GEN;
                        for (int k = 0; k < C_NK_MAX; k++) begin
                            if (k < int'(nk_in)) begin
                                store_d[k] = key_word[k];
                                win_d[k]   = key_word[C_WIN_AW'(nk_in - 4'd1 - 4'(k))];
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GEN: begin
                store_d[i_q] = new_word;
                win_d[0]     = new_word;
                for (int k = 1; k < C_NK_MAX; k++) begin
                    win_d[k] = win_q[k-1];
                end
                if (mod_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                // Nk=8 gives nk_cur[2:0]=0, so the wrap point becomes 7.
                mod_d = (mod_q == (nk_cur[2:0] - 3'd1)) ? 3'd0 : (mod_q + 3'd1);
                i_d   = i_q + C_AW'(1);
                if (i_q == last_idx) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read port: free-running, indices beyond Nr of the latched mode read 0.
    always_comb begin
        rk_data_d = '0;
        if (rk_idx <= nr_cur) begin
            rk_data_d = {store_q[rk_base],
                         store_q[rk_base + C_AW'(1)],
                         store_q[rk_base + C_AW'(2)],
                         store_q[rk_base + C_AW'(3)]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_len_q <= 2'd0;
            rcon_q    <= 8'h00;
            i_q       <= '0;
            mod_q     <= 3'd0;
            win_q     <= '{default: '0};
            store_q   <= '{default: '0};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rk_data_q <= '0;
        end else begin
            state_q   <= state_d;
            key_len_q <= key_len_d;
            rcon_q    <= rcon_d;
            i_q       <= i_d;
            mod_q     <= mod_d;
            win_q     <= win_d;
            store_q   <= store_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rk_data_q <= rk_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign rk_data = rk_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule
// Purpose  : Scoreboard bench for aes_key_schedule using FIPS-197 vectors.
//            Stimulus pushes expected read data and expected busy lengths;
//            a monitor pops and compares when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    localparam logic [127:0] C_K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] C_K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] C_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] C_RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_RK192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] C_RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] C_RK256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] C_RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] C_RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] cipher_key = '0;
    logic         busy, done, ready, err;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_data;

    typedef struct {
        logic [127:0] data;
        string        name;
    } rd_exp_t;

    rd_exp_t exp_rd_q [$];
    int      exp_len_q [$];
    logic    rd_req = 1'b0;
    int      checks = 0;
    int      errors = 0;

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .cipher_key (cipher_key),
        .busy       (busy),
        .done       (done),
        .ready      (ready),
        .err        (err),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: read data one edge after a request, busy length on each done.
    initial begin : monitor
        int  busy_cnt;
        logic req;
        rd_exp_t e;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            req = rd_req;
            #1;
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (exp_len_q.size() == 0) begin
                        check("unexpected_done", 128'(exp_len_q.size()), 128'd1);
                    end else begin
                        check("busy_cycles", 128'(busy_cnt), 128'(exp_len_q.pop_front()));
                    end
                    check("done_busy_low", 128'(busy), 128'd0);
                    check("done_ready_high", 128'(ready), 128'd1);
                    busy_cnt = 0;
                end
            end
            if (req) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_read", 128'(exp_rd_q.size()), 128'd1);
                end else begin
                    e = exp_rd_q.pop_front();
                    check(e.name, rk_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string name);
        rd_exp_t e;
        @(negedge clk);
        rk_idx = idx;
        rd_req = 1'b1;
        e.data = exp;
        e.name = name;
        exp_rd_q.push_back(e);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic run_start(input logic [1:0] kl, input logic [255:0] key,
                             input int exp_busy, input bit expect_done);
        @(negedge clk);
        key_len    = kl;
        cipher_key = key;
        start      = 1'b1;
        if (expect_done) exp_len_q.push_back(exp_busy);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves the caller at the negedge inside the done cycle.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(done), 128'd1);
    endtask

    initial begin : stimulus
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        read_rk(4'd0, 128'd0, "rst_rk0");

        // AES-128, with junk in the unused low half of cipher_key
        run_start(2'd0, {C_K128, 128'h0123456789abcdeffedcba9876543210}, 40, 1'b1);
        wait_done("done_128");
        read_rk(4'd0, C_K128, "aes128_rk0");
        read_rk(4'd1, C_RK128_1, "aes128_rk1");
        read_rk(4'd10, C_RK128_10, "aes128_rk10");
        read_rk(4'd11, 128'd0, "aes128_rk11_oob");

        // Illegal key_len: err pulse only, schedule kept
        @(negedge clk);
        key_len = 2'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_err", 128'(err), 128'd1);
        check("illegal_busy", 128'(busy), 128'd0);
        check("illegal_ready", 128'(ready), 128'd1);
        @(negedge clk);
        check("illegal_err_pulse", 128'(err), 128'd0);
        read_rk(4'd10, C_RK128_10, "illegal_keep_rk10");

        // AES-192
        run_start(2'd1, {C_K192, 64'hdeadbeefcafef00d}, 46, 1'b1);
        wait_done("done_192");
        read_rk(4'd0, C_RK192_0, "aes192_rk0");
        read_rk(4'd12, C_RK192_12, "aes192_rk12");
        read_rk(4'd13, 128'd0, "aes192_rk13_oob");

        // AES-256
        run_start(2'd2, C_K256, 52, 1'b1);
        wait_done("done_256");
        read_rk(4'd0, C_RK256_0, "aes256_rk0");
        read_rk(4'd1, C_RK256_1, "aes256_rk1");
        read_rk(4'd14, C_RK256_14, "aes256_rk14");
        read_rk(4'd15, 128'd0, "aes256_rk15_oob");

        // Start during GEN is ignored, then reset mid-expansion
        run_start(2'd0, {C_K128, 128'h0}, 0, 1'b0);
        repeat (9) @(negedge clk);
        key_len = 2'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midgen_no_err", 128'(err), 128'd0);
        check("midgen_busy", 128'(busy), 128'd1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 128'(busy), 128'd0);
        check("async_rst_ready", 128'(ready), 128'd0);
        check("async_rst_rk_data", rk_data, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        read_rk(4'd0, 128'd0, "post_rst_rk0");
        check("post_rst_busy", 128'(busy), 128'd0);
        run_start(2'd0, {C_K128, 128'h0}, 40, 1'b1);
        wait_done("done_128_rerun");
        read_rk(4'd1, C_RK128_1, "rerun_rk1");
        read_rk(4'd10, C_RK128_10, "rerun_rk10");

        // Back-to-back: 256 run, then a 128 start in the done cycle
        run_start(2'd2, C_K256, 52, 1'b1);
        wait_done("done_b2b_256");
        key_len    = 2'd0;
        cipher_key = {C_K128, 128'h0};
        start      = 1'b1;
        exp_len_q.push_back(40);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 128'(busy), 128'd1);
        check("b2b_ready_drop", 128'(ready), 128'd0);
        wait_done("done_b2b_128");
        read_rk(4'd10, C_RK128_10, "b2b_rk10");
        read_rk(4'd0, C_K128, "b2b_rk0");
        read_rk(4'd14, 128'd0, "b2b_rk14_oob");

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 128'(exp_rd_q.size()), 128'd0);
        check("len_queue_drained", 128'(exp_len_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
